// File: rtl/typedefs.sv
// Shared opcode encoding for the accumulator ALU and its consumers.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

endpackage

// File: rtl/alu.sv
// Accumulator ALU: registered result, combinational zero flag on accum.
// Optional registered adder carry-out enabled by defining ALU_CARRY_EN.
module alu
  import typedefs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  input  opcode_t          opcode,
  output logic [WIDTH-1:0] out,
`ifdef ALU_CARRY_EN
  output logic             carry,
`endif
  output logic             zero
);

  logic [WIDTH-1:0] out_d, out_q;

`ifdef ALU_CARRY_EN
  logic [WIDTH:0] sum;
  logic           carry_d, carry_q;

  assign sum = {1'b0, accum} + {1'b0, data};

  always_comb begin
    carry_d = 1'b0;
    if (opcode == ADD) carry_d = sum[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign carry = carry_q;
`else
  logic [WIDTH-1:0] sum;

  // Overflow beyond WIDTH is intentionally dropped.
  assign sum = accum + data;
`endif

  always_comb begin
    out_d = accum;
    unique case (opcode)
      ADD:     out_d = sum[WIDTH-1:0];
      AND:     out_d = accum & data;
      XOR:     out_d = accum ^ data;
      LDA:     out_d = data;
      default: out_d = accum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out  = out_q;
  assign zero = (accum == '0);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/zero corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_alu;
  import typedefs::*;

  logic       clk;
  logic       rst;
  logic [7:0] accum;
  logic [7:0] data;
  opcode_t    opcode;
  logic [7:0] out;
  logic       zero;
`ifdef ALU_CARRY_EN
  logic       carry;
`endif

  int checks = 0;
  int failures = 0;

  alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .accum  (accum),
    .data   (data),
    .opcode (opcode),
    .out    (out),
`ifdef ALU_CARRY_EN
    .carry  (carry),
`endif
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    opcode_t    op;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_out;
    logic       exp_zero;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(opcode_t op, logic [7:0] a, logic [7:0] d,
                              logic [7:0] e, logic z, logic c);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.exp_out = e; v.exp_zero = z; v.exp_carry = c;
    return v;
  endfunction

  // Reference model written from the operation rules with integer arithmetic.
  function automatic int model_out(int op, int a, int d);
    if (op == 2) return (a + d) % 256;
    if (op == 3) return a & d;
    if (op == 4) return a ^ d;
    if (op == 5) return d;
    return a;
  endfunction

  function automatic int model_carry(int op, int a, int d);
    return (op == 2 && (a + d) > 255) ? 1 : 0;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step(opcode_t op, logic [7:0] a, logic [7:0] d);
    @(negedge clk);
    opcode = op; accum = a; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    opcode_t seq_ops[8];
    int ea, ed, eo;
    rst = 1'b1; accum = 8'h00; data = 8'h00; opcode = HLT;
    #1;
    check("reset_out", int'(out), 0);
`ifdef ALU_CARRY_EN
    check("reset_carry", int'(carry), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk(ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0));
    vecs.push_back(mk(ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(AND, 8'h03, 8'h02, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(AND, 8'h08, 8'h0A, 8'h08, 1'b0, 1'b0));
    vecs.push_back(mk(XOR, 8'h03, 8'h02, 8'h01, 1'b0, 1'b0));
    vecs.push_back(mk(XOR, 8'h08, 8'h0A, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(XOR, 8'h03, 8'h15, 8'h16, 1'b0, 1'b0));
    vecs.push_back(mk(LDA, 8'h03, 8'h02, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(LDA, 8'h08, 8'h0A, 8'h0A, 1'b0, 1'b0));
    vecs.push_back(mk(HLT, 8'h03, 8'h02, 8'h03, 1'b0, 1'b0));
    vecs.push_back(mk(SKZ, 8'h03, 8'h02, 8'h03, 1'b0, 1'b0));
    vecs.push_back(mk(JMP, 8'h03, 8'h02, 8'h03, 1'b0, 1'b0));
    vecs.push_back(mk(STO, 8'h03, 8'h02, 8'h03, 1'b0, 1'b0));
    vecs.push_back(mk(HLT, 8'h08, 8'h0A, 8'h08, 1'b0, 1'b0));
    vecs.push_back(mk(SKZ, 8'h08, 8'h0A, 8'h08, 1'b0, 1'b0));
    vecs.push_back(mk(JMP, 8'h08, 8'h0A, 8'h08, 1'b0, 1'b0));
    vecs.push_back(mk(STO, 8'h08, 8'h0A, 8'h08, 1'b0, 1'b0));
    vecs.push_back(mk(STO, 8'h00, 8'h0A, 8'h00, 1'b1, 1'b0));
    vecs.push_back(mk(LDA, 8'h00, 8'h0A, 8'h0A, 1'b1, 1'b0));

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d_%s_out", i, vecs[i].op.name()), int'(out), int'(vecs[i].exp_out));
      check($sformatf("vec%0d_zero", i), int'(zero), int'(vecs[i].exp_zero));
`ifdef ALU_CARRY_EN
      check($sformatf("vec%0d_carry", i), int'(carry), int'(vecs[i].exp_carry));
`endif
    end

    // Asynchronous reset in the middle of the low phase.
    step(LDA, 8'h00, 8'h55);
    check("pre_reset_out", int'(out), 'h55);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", int'(out), 0);
    @(posedge clk);
    #1;
    check("reset_held_out", int'(out), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_out", int'(out), 'h55);

    // Zero follows accum between edges.
    @(negedge clk);
    opcode = HLT; accum = 8'h00; data = 8'h0A;
    #1;
    check("zero_comb_high", int'(zero), 1);
    #2 accum = 8'h01;
    #1;
    check("zero_comb_fall", int'(zero), 0);

    // Back-to-back distinct opcodes, one per cycle.
    seq_ops = '{ADD, AND, XOR, LDA, HLT, SKZ, STO, JMP};
    for (int i = 0; i < 8; i++) begin
      ea = 8'h30 + i * 7;
      ed = 8'hC5 - i * 3;
      step(seq_ops[i], 8'(ea), 8'(ed));
      check($sformatf("b2b_%s", seq_ops[i].name()), int'(out), model_out(int'(seq_ops[i]), ea, ed));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(7));
      ea = int'($urandom_range(255));
      ed = int'($urandom_range(255));
      if ($urandom_range(9) == 0) ea = 0;
      step(opcode_t'(op), 8'(ea), 8'(ed));
      eo = model_out(op, ea, ed);
      check($sformatf("rand%0d_out", i), int'(out), eo);
      check($sformatf("rand%0d_zero", i), int'(zero), (ea == 0) ? 1 : 0);
`ifdef ALU_CARRY_EN
      check($sformatf("rand%0d_carry", i), int'(carry), model_carry(op, ea, ed));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
